alu_cmd_sequencer: RTL

- Initiator side of the ALU: takes a byte-serial command stream, frames it into opcode/a/b, and drives the combinational ALU for one evaluation cycle.
- Captures the 16-bit result and returns it as a byte-serial response stream.
- Sits between the chip's byte I/O path and the ALU instance; the only agent that asserts the ALU enable.

---
 rtl/alu_cmd_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: frames byte-serial op/a/b commands, drives one ALU evaluation, returns the 16-bit result as bytes.
// Optional build macro ALU_SEQ_SHORT_RESP_EN: non-multiply, non-error results return only the low byte.
module alu_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_opcode,
  output logic        alu_ena,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        cmd_err,
  output logic        timeout
);
  localparam logic [2:0] GET_OP  = 3'd0;
  localparam logic [2:0] GET_A   = 3'd1;
  localparam logic [2:0] GET_B   = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND_HI = 3'd4;
  localparam logic [2:0] SEND_LO = 3'd5;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic             err_q, err_d;
  logic [15:0]      resp_q, resp_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             in_xfer, waiting, short_resp;

  assign in_ready   = (state_q == GET_OP) || (state_q == GET_A) || (state_q == GET_B);
  assign in_xfer    = in_valid && in_ready;
  assign waiting    = (state_q == GET_A) || (state_q == GET_B);
  assign out_valid  = (state_q == SEND_HI) || (state_q == SEND_LO);
  assign out_data   = (state_q == SEND_HI) ? resp_q[15:8] : resp_q[7:0];
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign alu_ena    = (state_q == EXEC) && !err_q;
  assign cmd_err    = (state_q == EXEC) && err_q;
  assign busy       = state_q != GET_OP;
  // An arriving byte beats a counter that would expire in the same cycle.
  assign timeout    = (TIMEOUT_CYCLES != 0) && waiting && !in_xfer && (tmo_q == TMO_LAST);
`ifdef ALU_SEQ_SHORT_RESP_EN
  assign short_resp = !err_q && (op_q != 3'b010);
`else
  assign short_resp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    resp_d  = resp_q;
    tmo_d   = tmo_q;
    case (state_q)
      GET_OP: if (in_xfer) begin
        op_d    = in_data[2:0];
        err_d   = |in_data[7:3];
        tmo_d   = '0;
        state_d = GET_A;
      end
      GET_A: if (in_xfer) begin
        a_d     = in_data;
        tmo_d   = '0;
        state_d = GET_B;
      end else if (timeout) state_d = GET_OP;
      else tmo_d = tmo_q + TMO_W'(1);
      GET_B: if (in_xfer) begin
        b_d     = in_data;
        tmo_d   = '0;
        state_d = EXEC;
      end else if (timeout) state_d = GET_OP;
      else tmo_d = tmo_q + TMO_W'(1);
      EXEC: begin
        resp_d  = err_q ? 16'hFFFF : alu_result;
        state_d = short_resp ? SEND_LO : SEND_HI;
      end
      SEND_HI: state_d = out_ready ? SEND_LO : SEND_HI;
      SEND_LO: state_d = out_ready ? GET_OP : SEND_LO;
      default: state_d = GET_OP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_OP;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      resp_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      tmo_q   <= tmo_d;
    end
  end
endmodule
